// File: rtl/ifft8_serial.sv
// ifft8_serial: 8-point radix-2 inverse FFT with one time-shared butterfly.
// Bins stream in (natural order, stored bit-reversed), 12 butterfly cycles run
// in place, then 8 time samples stream out in natural order. Each stage halves
// its result, so the whole transform carries the 1/8 IDFT scale.
// Build option: define IFFT_SAT_EN to saturate every stage result to the
// DW-bit signed range instead of letting it wrap.
module ifft8_serial #(
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  localparam int PW = DW + TW + 1;

  // Twiddle constants in Q1.(TW-2); cos(45deg) is 11585 at TW=16 and scales with TW.
  localparam int C_INT = (TW >= 16) ? (32'sd11585 <<< (TW - 16)) : (32'sd11585 >>> (16 - TW));
  localparam logic signed [TW-1:0] W_ONE = {2'b01, {(TW-2){1'b0}}};
  localparam logic signed [TW-1:0] W_C   = TW'(C_INT);
  localparam logic signed [TW-1:0] W_NC  = -W_C;

  // Rounding constant: half an LSB of the product after the Q-format shift.
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (TW - 3);

  // Stage saturation bounds, expressed in the widened sum width.
  localparam logic signed [DW+2:0] MAX_V = {4'b0000, {(DW-1){1'b1}}};
  localparam logic signed [DW+2:0] MIN_V = {4'b1111, {(DW-1){1'b0}}};

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Inverse-transform twiddle exp(+j*2*pi*m/8), packed {re, im}.
  function automatic logic [2*TW-1:0] twiddle(input logic [1:0] m);
    case (m)
      2'd0:    return {W_ONE, {TW{1'b0}}};
      2'd1:    return {W_C, W_C};
      2'd2:    return {{TW{1'b0}}, W_ONE};
      2'd3:    return {W_NC, W_C};
      default: return {W_ONE, {TW{1'b0}}};
    endcase
  endfunction

  // Reduce a halved butterfly sum to DW bits (wrap, or clamp when enabled).
  function automatic logic signed [DW-1:0] fit(input logic signed [DW+2:0] v);
`ifdef IFFT_SAT_EN
    if (v > MAX_V) begin
      return MAX_V[DW-1:0];
    end else if (v < MIN_V) begin
      return MIN_V[DW-1:0];
    end else begin
      return DW'(v);
    end
`else
    return DW'(v);
`endif
  endfunction

  state_t state;
  logic [2:0] load_cnt;
  logic [1:0] stage;
  logic [1:0] bfly;
  logic [2:0] out_idx;

  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  logic [2:0] idx_a, idx_b, h_mask;
  logic [1:0] tw_m;

  logic [2*TW-1:0]        tw_s;
  logic signed [TW-1:0]   w_re, w_im;
  logic signed [DW-1:0]   a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]   bre_x, bim_x, wre_x, wim_x, p_re, p_im;
  logic signed [DW+1:0]   t_re, t_im;
  logic signed [DW+2:0]   sa_re, sa_im, sb_re, sb_im;
  logic signed [DW-1:0]   na_re, na_im, nb_re, nb_im;

  // Map (stage, butterfly) to the pair (i, i+h) and its twiddle index.
  always_comb begin
    idx_a  = 3'd0;
    h_mask = 3'b001;
    tw_m   = 2'd0;
    case (stage)
      2'd0: begin
        idx_a  = {bfly, 1'b0};
        h_mask = 3'b001;
        tw_m   = 2'd0;
      end
      2'd1: begin
        idx_a  = {bfly[1], 1'b0, bfly[0]};
        h_mask = 3'b010;
        tw_m   = {bfly[0], 1'b0};
      end
      2'd2: begin
        idx_a  = {1'b0, bfly};
        h_mask = 3'b100;
        tw_m   = bfly;
      end
      default: begin
        idx_a  = {bfly, 1'b0};
        h_mask = 3'b001;
        tw_m   = 2'd0;
      end
    endcase
    idx_b = idx_a | h_mask;
  end

  // Butterfly datapath: t = b*W rounded, then a' = (a+t)/2, b' = (a-t)/2.
  always_comb begin
    tw_s  = twiddle(tw_m);
    w_re  = tw_s[2*TW-1:TW];
    w_im  = tw_s[TW-1:0];
    a_re  = mem_re[idx_a];
    a_im  = mem_im[idx_a];
    b_re  = mem_re[idx_b];
    b_im  = mem_im[idx_b];
    bre_x = {{(TW+1){b_re[DW-1]}}, b_re};
    bim_x = {{(TW+1){b_im[DW-1]}}, b_im};
    wre_x = {{(DW+1){w_re[TW-1]}}, w_re};
    wim_x = {{(DW+1){w_im[TW-1]}}, w_im};
    p_re  = bre_x * wre_x - bim_x * wim_x;
    p_im  = bre_x * wim_x + bim_x * wre_x;
    t_re  = (DW+2)'((p_re + RND) >>> (TW - 2));
    t_im  = (DW+2)'((p_im + RND) >>> (TW - 2));
    sa_re = {{3{a_re[DW-1]}}, a_re} + {t_re[DW+1], t_re};
    sa_im = {{3{a_im[DW-1]}}, a_im} + {t_im[DW+1], t_im};
    sb_re = {{3{a_re[DW-1]}}, a_re} - {t_re[DW+1], t_re};
    sb_im = {{3{a_im[DW-1]}}, a_im} - {t_im[DW+1], t_im};
    na_re = fit(sa_re >>> 1);
    na_im = fit(sa_im >>> 1);
    nb_re = fit(sb_re >>> 1);
    nb_im = fit(sb_im >>> 1);
  end

  // Control FSM, in-place buffer updates and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      load_cnt  <= 3'd0;
      stage     <= 2'd0;
      bfly      <= 2'd0;
      out_idx   <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_re    <= {DW{1'b0}};
      out_im    <= {DW{1'b0}};
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            mem_re[bitrev3(load_cnt)] <= in_re;
            mem_im[bitrev3(load_cnt)] <= in_im;
            if (load_cnt == 3'd7) begin
              load_cnt <= 3'd0;
              stage    <= 2'd0;
              bfly     <= 2'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_COMPUTE;
            end else begin
              load_cnt <= load_cnt + 3'd1;
            end
          end else begin
            load_cnt <= load_cnt;
          end
        end
        ST_COMPUTE: begin
          mem_re[idx_a] <= na_re;
          mem_im[idx_a] <= na_im;
          mem_re[idx_b] <= nb_re;
          mem_im[idx_b] <= nb_im;
          if (bfly == 2'd3) begin
            bfly <= 2'd0;
            if (stage == 2'd2) begin
              stage   <= 2'd0;
              out_idx <= 3'd0;
              state   <= ST_UNLOAD;
            end else begin
              stage <= stage + 2'd1;
            end
          end else begin
            bfly <= bfly + 2'd1;
          end
        end
        ST_UNLOAD: begin
          if (!out_valid) begin
            // First sample: the buffer holds the finished result by now.
            out_valid <= 1'b1;
            out_re    <= mem_re[out_idx];
            out_im    <= mem_im[out_idx];
            out_last  <= (out_idx == 3'd7);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= 3'd0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_LOAD;
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_re   <= mem_re[out_idx + 3'd1];
              out_im   <= mem_im[out_idx + 3'd1];
              out_last <= (out_idx == 3'd6);
            end
          end else begin
            out_valid <= out_valid;
          end
        end
        default: begin
          state     <= ST_LOAD;
          load_cnt  <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_serial.sv
// Testbench for ifft8_serial: scoreboard of expected samples fed by the
// stimulus process, drained by an independent output monitor. Directed frames
// are checked against a floating-point IDFT, random frames bit-exactly
// against an integer radix-2 IDFT model.
module tb_ifft8_serial;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_re, in_im, out_re, out_im;

  ifft8_serial #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  real eq_re[$];
  real eq_im[$];
  real eq_tol[$];
  bit  eq_last[$];

  longint fr[8];
  longint fi[8];
  longint WR[4] = '{16384, 11585, 0, -11585};
  longint WI[4] = '{0, 11585, 16384, 11585};

  task automatic check_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_real(input string name, input longint act, input real req, input real tol);
    real d;
    checks++;
    d = act - req;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%f tol=%f at %0t", name, act, req, tol, $time);
    end
  endtask

  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic longint wrapn(input longint v, input int n);
    return (v <<< (64 - n)) >>> (64 - n);
  endfunction

  function automatic longint stage_fit(input longint v);
`ifdef IFFT_SAT_EN
    longint hi = (longint'(1) <<< (DW - 1)) - 1;
    longint lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return wrapn(v, DW);
`endif
  endfunction

  // Exact IDFT as a floating-point sum; expected samples pushed with a tolerance.
  task automatic push_float(input real tol);
    real sr, si, ang;
    for (int n = 0; n < 8; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 8; k++) begin
        ang = 2.0 * PI * k * n / 8.0;
        sr += fr[k] * $cos(ang) - fi[k] * $sin(ang);
        si += fr[k] * $sin(ang) + fi[k] * $cos(ang);
      end
      eq_re.push_back(sr / 8.0);
      eq_im.push_back(si / 8.0);
      eq_tol.push_back(tol);
      eq_last.push_back(n == 7);
    end
  endtask

  // Integer radix-2 decimation-in-time IDFT with per-stage halving.
  task automatic push_fixed();
    longint ar[8], ai[8];
    longint br, bi, pr, pim, tr, ti, xr, xi;
    int h, j, m;
    for (int k = 0; k < 8; k++) begin
      ar[brev(k)] = fr[k];
      ai[brev(k)] = fi[k];
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int i = 0; i < 8; i++) begin
        j = i % (2 * h);
        if (j < h) begin
          m = j * (4 >> s);
          br = ar[i + h];
          bi = ai[i + h];
          pr  = br * WR[m] - bi * WI[m];
          pim = br * WI[m] + bi * WR[m];
          tr = wrapn((pr  + (longint'(1) <<< (TW - 3))) >>> (TW - 2), DW + 2);
          ti = wrapn((pim + (longint'(1) <<< (TW - 3))) >>> (TW - 2), DW + 2);
          xr = ar[i];
          xi = ai[i];
          ar[i]     = stage_fit((xr + tr) >>> 1);
          ai[i]     = stage_fit((xi + ti) >>> 1);
          ar[i + h] = stage_fit((xr - tr) >>> 1);
          ai[i + h] = stage_fit((xi - ti) >>> 1);
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      eq_re.push_back(ar[n]);
      eq_im.push_back(ai[n]);
      eq_tol.push_back(0.0);
      eq_last.push_back(n == 7);
    end
  endtask

  function automatic void set_frame(input longint r0, input longint i0, input int only_k, input bit all);
    for (int k = 0; k < 8; k++) begin
      fr[k] = (all || k == only_k) ? r0 : 0;
      fi[k] = (all || k == only_k) ? i0 : 0;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the edge that took bin 7.
  task automatic send_frame(input int gap_max, input bit hold_valid);
    int n, g;
    for (int k = 0; k < 8; k++) begin
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_re = DW'(fr[k]);
      in_im = DW'(fi[k]);
      n = 0;
      while (!in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        check_int("in_ready_timeout", n, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (hold_valid) begin
      in_re = DW'($urandom);
      in_im = DW'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq_re.size() != 0 || !in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (n >= 2000) check_int("drain_timeout", n, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_int({tag, "_in_ready"}, in_ready, 1);
    check_int({tag, "_out_valid"}, out_valid, 0);
    check_int({tag, "_busy"}, busy, 0);
  endtask

  // Sink readiness, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    bit stall_prev, last_pending;
    logic signed [DW-1:0] p_re, p_im;
    logic p_last;
    real er, ei, et;
    bit el;
    stall_prev = 1'b0;
    last_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        last_pending = 1'b0;
      end else begin
        if (last_pending) begin
          check_int("in_ready_after_last", in_ready, 1);
          check_int("out_valid_after_last", out_valid, 0);
          last_pending = 1'b0;
        end
        if (out_valid) begin
          if (stall_prev) begin
            check_int("stall_re", out_re, p_re);
            check_int("stall_im", out_im, p_im);
            check_int("stall_last", out_last, p_last);
          end
          if (out_ready) begin
            check_int("no_overlap_in_ready", in_ready, 0);
            if (eq_re.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output actual=(%0d,%0d) required=none", out_re, out_im);
            end else begin
              er = eq_re.pop_front();
              ei = eq_im.pop_front();
              et = eq_tol.pop_front();
              el = eq_last.pop_front();
              check_real("out_re", out_re, er, et);
              check_real("out_im", out_im, ei, et);
              check_int("out_last", out_last, el);
            end
            if (out_last) last_pending = 1'b1;
            stall_prev = 1'b0;
          end else begin
            stall_prev = 1'b1;
            p_re = out_re;
            p_im = out_im;
            p_last = out_last;
          end
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus: directed frames, latency and abort cases, then random frames.
  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check_int("reset_out_last", out_last, 0);
    check_int("reset_out_re", out_re, 0);
    check_int("reset_out_im", out_im, 0);
    rst = 1'b0;
    @(negedge clk);

    // DC bin -> constant 100, and first-output latency of 13 cycles.
    set_frame(800, 0, 0, 1'b0);
    push_float(0.5);
    send_frame(0, 1'b0);
    check_int("busy_in_compute", busy, 1);
    check_int("in_ready_in_compute", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int("latency", n, 13);
    drain();

    // Single rotating tone: amplitude 1000, within 1 LSB.
    set_frame(8000, 0, 1, 1'b0);
    push_float(1.0);
    send_frame(0, 1'b0);
    drain();

    // Flat spectrum -> impulse at n=0.
    set_frame(80, -40, 0, 1'b1);
    push_float(0.5);
    send_frame(0, 1'b0);
    drain();

    // Alternating sink stalls with the producer holding valid high throughout.
    ready_mode = 1;
    set_frame(800, 0, 0, 1'b0);
    push_float(0.5);
    send_frame(0, 1'b1);
    drain();
    ready_mode = 0;

    // Partially loaded frame discarded by reset.
    in_valid = 1'b1;
    in_re = 16'sd1234;
    in_im = -16'sd77;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("partial_rst");

    // Reset on the 5th compute cycle aborts the frame.
    set_frame(800, 0, 0, 1'b0);
    push_float(0.5);
    send_frame(0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("compute_rst");
    eq_re.delete();
    eq_im.delete();
    eq_tol.delete();
    eq_last.delete();
    set_frame(800, 0, 0, 1'b0);
    push_float(0.5);
    send_frame(0, 1'b0);
    drain();

    // Random full-scale frames within the wrap-free range, random stalls and gaps.
    ready_mode = 2;
    for (int f = 0; f < 200; f++) begin
      for (int k = 0; k < 8; k++) begin
        fr[k] = longint'(int'($urandom_range(32766, 0))) - 16383;
        fi[k] = longint'(int'($urandom_range(32766, 0))) - 16383;
      end
      push_fixed();
      send_frame(2, 1'b0);
    end
    drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", eq_re.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
